// File: rtl/regfile_wb_sequencer_pkg.sv
// Shared Y86-64 constants and write-back sequencer state encoding.
// Imported by the sequencer and its bench.
package y86_pkg;

    localparam logic [3:0] REG_NONE = 4'hF;
    localparam logic [3:0] REG_RSP  = 4'h4;

    localparam logic [3:0] IHALT   = 4'd0;
    localparam logic [3:0] INOP    = 4'd1;
    localparam logic [3:0] IRRMOVQ = 4'd2;
    localparam logic [3:0] IIRMOVQ = 4'd3;
    localparam logic [3:0] IRMMOVQ = 4'd4;
    localparam logic [3:0] IMRMOVQ = 4'd5;
    localparam logic [3:0] IOPQ    = 4'd6;
    localparam logic [3:0] IJXX    = 4'd7;
    localparam logic [3:0] ICALL   = 4'd8;
    localparam logic [3:0] IRET    = 4'd9;
    localparam logic [3:0] IPUSHQ  = 4'd10;
    localparam logic [3:0] IPOPQ   = 4'd11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR_E = 2'd1,
        WR_M = 2'd2,
        NOWR = 2'd3
    } wb_state_t;

    // First active state of a freshly captured bundle.
    function automatic logic [1:0] first_state(input logic need_e, input logic need_m);
        if (need_e)
            return WR_E;
        else if (need_m)
            return WR_M;
        else
            return NOWR;
    endfunction

endpackage

// File: rtl/regfile_wb_sequencer_if.sv
// Write-back bundle handshake plus register-file write port.
// slave = sequencer side, master = upstream stage / observer side.
interface regfile_wb_sequencer_if #(
    parameter int DATA_W = 64,
    parameter int REG_W  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [REG_W-1:0]  in_dstE;
    logic [DATA_W-1:0] in_valE;
    logic [REG_W-1:0]  in_dstM;
    logic [DATA_W-1:0] in_valM;
    logic              wr_en;
    logic [REG_W-1:0]  wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              retire;

    modport slave (
        input  in_valid, in_dstE, in_valE, in_dstM, in_valM,
        output in_ready, wr_en, wr_addr, wr_data, retire
    );

    modport master (
        output in_valid, in_dstE, in_valE, in_dstM, in_valM,
        input  in_ready, wr_en, wr_addr, wr_data, retire
    );
endinterface

// File: rtl/regfile_wb_sequencer.sv
// Serialises one instruction's E/M write-back onto a single regfile port; first write 1 cycle after accept,
// in_ready low only during the E half of a dual write. WB_PERF_CNT_EN adds retire/dual-write counters.
module regfile_wb_sequencer
    import y86_pkg::*;
#(
    parameter int               DATA_W = 64,
    parameter int               REG_W  = 4,
    parameter logic [REG_W-1:0] RNONE  = {REG_W{1'b1}}
) (
    input  logic                    clk,
    input  logic                    rst_n,
    regfile_wb_sequencer_if.slave   wb
`ifdef WB_PERF_CNT_EN
    ,
    output logic [31:0]             perf_retired,
    output logic [31:0]             perf_dual
`endif
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_WR_E = WR_E;
    localparam logic [1:0] S_WR_M = WR_M;
    localparam logic [1:0] S_NOWR = NOWR;

    logic [1:0]        state_q, state_d;
    logic              alive_q;
    logic [REG_W-1:0]  dst_e_q, dst_m_q;
    logic [DATA_W-1:0] val_e_q, val_m_q;
    logic [DATA_W-1:0] last_data_q;
    logic              need_e_q, need_m_q;

    logic              need_e_in, need_m_in, accept;
    logic              wr_en_c, retire_c, in_ready_c;
    logic [REG_W-1:0]  wr_addr_c;
    logic [DATA_W-1:0] wr_data_c;

    // M wins over E when both target the same register (popq %rsp).
    assign need_m_in = (wb.in_dstM != RNONE);
    assign need_e_in = (wb.in_dstE != RNONE) && !(need_m_in && (wb.in_dstE == wb.in_dstM));
    assign accept    = wb.in_valid && in_ready_c;

    always_comb begin
        wr_en_c   = 1'b0;
        wr_addr_c = RNONE;
        wr_data_c = last_data_q;
        retire_c  = 1'b0;
        case (state_q)
            S_WR_E: begin
                wr_en_c   = 1'b1;
                wr_addr_c = dst_e_q;
                wr_data_c = val_e_q;
                retire_c  = !need_m_q;
            end
            S_WR_M: begin
                wr_en_c   = 1'b1;
                wr_addr_c = dst_m_q;
                wr_data_c = val_m_q;
                retire_c  = 1'b1;
            end
            S_NOWR: retire_c = 1'b1;
            default: ;
        endcase
    end

    // alive_q keeps ready low until the first edge after reset release.
    assign in_ready_c = alive_q && ((state_q == S_IDLE) || retire_c);

    always_comb begin
        state_d = S_IDLE;
        if ((state_q == S_WR_E) && need_m_q)
            state_d = S_WR_M;
        else if (accept)
            state_d = first_state(need_e_in, need_m_in);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            alive_q     <= 1'b0;
            dst_e_q     <= RNONE;
            dst_m_q     <= RNONE;
            val_e_q     <= '0;
            val_m_q     <= '0;
            need_e_q    <= 1'b0;
            need_m_q    <= 1'b0;
            last_data_q <= '0;
        end else begin
            state_q <= state_d;
            alive_q <= 1'b1;
            if (accept) begin
                dst_e_q  <= wb.in_dstE;
                dst_m_q  <= wb.in_dstM;
                val_e_q  <= wb.in_valE;
                val_m_q  <= wb.in_valM;
                need_e_q <= need_e_in;
                need_m_q <= need_m_in;
            end
            if (wr_en_c)
                last_data_q <= wr_data_c;
        end
    end

    assign wb.wr_en    = wr_en_c;
    assign wb.wr_addr  = wr_addr_c;
    assign wb.wr_data  = wr_data_c;
    assign wb.retire   = retire_c;
    assign wb.in_ready = in_ready_c;

`ifdef WB_PERF_CNT_EN
    logic [31:0] perf_retired_q, perf_dual_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_retired_q <= '0;
            perf_dual_q    <= '0;
        end else begin
            if (retire_c)
                perf_retired_q <= perf_retired_q + 32'd1;
            if (accept && need_e_in && need_m_in)
                perf_dual_q <= perf_dual_q + 32'd1;
        end
    end

    assign perf_retired = perf_retired_q;
    assign perf_dual    = perf_dual_q;
`endif

endmodule

// File: tb/tb_regfile_wb_sequencer.sv
// Directed scenarios plus a randomized run against a write-list reference model.
module tb_regfile_wb_sequencer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_wb_sequencer_if #(.DATA_W(64), .REG_W(4)) wb();

`ifdef WB_PERF_CNT_EN
    logic [31:0] perf_retired, perf_dual;
`endif

    regfile_wb_sequencer #(.DATA_W(64), .REG_W(4), .RNONE(4'hF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (wb)
`ifdef WB_PERF_CNT_EN
        ,
        .perf_retired (perf_retired),
        .perf_dual    (perf_dual)
`endif
    );

    int          checks = 0;
    int          failures = 0;
    int unsigned exp_retired = 0;
    int unsigned exp_dual = 0;

    typedef struct packed {
        logic        en;
        logic [3:0]  a;
        logic [63:0] d;
        logic        r;
    } ev_t;

    // Observation vector: {wr_en, wr_addr, wr_data, retire, in_ready}
    function automatic logic [70:0] sample();
        return {wb.wr_en, wb.wr_addr, wb.wr_data, wb.retire, wb.in_ready};
    endfunction

    function automatic logic [70:0] ev(input logic en, input logic [3:0] a, input logic [63:0] d,
                                       input logic r, input logic rdy);
        return {en, a, d, r, rdy};
    endfunction

    task automatic drive(input logic [3:0] de, input logic [63:0] ve, input logic [3:0] dm, input logic [63:0] vm);
        wb.in_valid = 1'b1;
        wb.in_dstE  = de;
        wb.in_valE  = ve;
        wb.in_dstM  = dm;
        wb.in_valM  = vm;
    endtask

    task automatic drive_idle();
        wb.in_valid = 1'b0;
    endtask

    task automatic check_perf(input string name);
`ifdef WB_PERF_CNT_EN
        checks++;
        if (perf_retired !== exp_retired) begin
            failures++;
            $display("FAIL %s_perf_retired: got %0d want %0d", name, perf_retired, exp_retired);
        end
        checks++;
        if (perf_dual !== exp_dual) begin
            failures++;
            $display("FAIL %s_perf_dual: got %0d want %0d", name, perf_dual, exp_dual);
        end
`else
        checks = checks + 0;
        if (name.len() == 0) $display("empty perf tag");
`endif
    endtask

    task automatic test_reset();
        logic [70:0] o, e;
        rst_n = 1'b0;
        drive(4'd3, 64'h77, 4'hF, 64'h0);
        repeat (2) @(negedge clk);
        o = sample(); e = ev(1'b0, 4'hF, 64'h0, 1'b0, 1'b0);
        checks++;
        if (o !== e) begin failures++; $display("FAIL reset_hold: got %h want %h (en,addr,data,retire,ready)", o, e); end
        drive_idle();
        rst_n = 1'b1;
        @(negedge clk);
        o = sample(); e = ev(1'b0, 4'hF, 64'h0, 1'b0, 1'b1);
        checks++;
        if (o !== e) begin failures++; $display("FAIL reset_release: got %h want %h", o, e); end
        check_perf("reset");
    endtask

    task automatic test_opq_back_to_back();
        logic [70:0] o, e;
        drive(4'd3, 64'h10, 4'hF, 64'hDEAD);
        @(negedge clk);
        o = sample(); e = ev(1'b1, 4'd3, 64'h10, 1'b1, 1'b1);
        checks++;
        if (o !== e) begin failures++; $display("FAIL opq_c1: got %h want %h", o, e); end
        drive(4'd2, 64'h20, 4'hF, 64'hBEEF);
        @(negedge clk);
        o = sample(); e = ev(1'b1, 4'd2, 64'h20, 1'b1, 1'b1);
        checks++;
        if (o !== e) begin failures++; $display("FAIL opq_c2: got %h want %h", o, e); end
        drive_idle();
        @(negedge clk);
        o = sample(); e = ev(1'b0, 4'hF, 64'h20, 1'b0, 1'b1);
        checks++;
        if (o !== e) begin failures++; $display("FAIL opq_idle: got %h want %h", o, e); end
        exp_retired += 2;
        check_perf("opq");
    endtask

    task automatic test_popq_rbx();
        logic [70:0] o, e;
        drive(4'd4, 64'h108, 4'd3, 64'hAB);
        @(negedge clk);
        o = sample(); e = ev(1'b1, 4'd4, 64'h108, 1'b0, 1'b0);
        checks++;
        if (o !== e) begin failures++; $display("FAIL popq_rbx_c1: got %h want %h", o, e); end
        drive_idle();
        @(negedge clk);
        o = sample(); e = ev(1'b1, 4'd3, 64'hAB, 1'b1, 1'b1);
        checks++;
        if (o !== e) begin failures++; $display("FAIL popq_rbx_c2: got %h want %h", o, e); end
        @(negedge clk);
        o = sample(); e = ev(1'b0, 4'hF, 64'hAB, 1'b0, 1'b1);
        checks++;
        if (o !== e) begin failures++; $display("FAIL popq_rbx_idle: got %h want %h", o, e); end
        exp_retired += 1;
        exp_dual += 1;
        check_perf("popq_rbx");
    endtask

    task automatic test_popq_rsp();
        logic [70:0] o, e;
        drive(4'd4, 64'h108, 4'd4, 64'h55);
        @(negedge clk);
        o = sample(); e = ev(1'b1, 4'd4, 64'h55, 1'b1, 1'b1);
        checks++;
        if (o !== e) begin failures++; $display("FAIL popq_rsp_c1: got %h want %h", o, e); end
        drive_idle();
        @(negedge clk);
        o = sample(); e = ev(1'b0, 4'hF, 64'h55, 1'b0, 1'b1);
        checks++;
        if (o !== e) begin failures++; $display("FAIL popq_rsp_no_e_write: got %h want %h", o, e); end
        exp_retired += 1;
        check_perf("popq_rsp");
    endtask

    task automatic test_nop();
        logic [70:0] o, e;
        drive(4'hF, 64'h1, 4'hF, 64'h2);
        @(negedge clk);
        o = sample(); e = ev(1'b0, 4'hF, 64'h55, 1'b1, 1'b1);
        checks++;
        if (o !== e) begin failures++; $display("FAIL nop_c1: got %h want %h", o, e); end
        drive_idle();
        @(negedge clk);
        o = sample(); e = ev(1'b0, 4'hF, 64'h55, 1'b0, 1'b1);
        checks++;
        if (o !== e) begin failures++; $display("FAIL nop_idle: got %h want %h", o, e); end
        exp_retired += 1;
        check_perf("nop");
    endtask

    task automatic test_reset_mid();
        logic [70:0] o, e;
        drive(4'd4, 64'h108, 4'd3, 64'hAB);
        @(posedge clk);
        #1;
        drive_idle();
        o = sample(); e = ev(1'b1, 4'd4, 64'h108, 1'b0, 1'b0);
        checks++;
        if (o !== e) begin failures++; $display("FAIL rstmid_wr_e: got %h want %h", o, e); end
        #1 rst_n = 1'b0;
        #1;
        o = sample(); e = ev(1'b0, 4'hF, 64'h0, 1'b0, 1'b0);
        checks++;
        if (o !== e) begin failures++; $display("FAIL rstmid_async_drop: got %h want %h", o, e); end
        exp_retired = 0;
        exp_dual = 0;
        @(negedge clk);
        @(negedge clk);
        o = sample();
        checks++;
        if (o !== e) begin failures++; $display("FAIL rstmid_held: got %h want %h", o, e); end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            o = sample(); e = ev(1'b0, 4'hF, 64'h0, 1'b0, 1'b1);
            checks++;
            if (o !== e) begin failures++; $display("FAIL rstmid_idle_%0d: got %h want %h", k, o, e); end
        end
        check_perf("rstmid");
    endtask

    task automatic test_random();
        ev_t         q[$];
        ev_t         cur;
        logic        idle, exp_rdy;
        logic [63:0] last_data;
        logic [70:0] o, e;
        logic [3:0]  de, dm;
        logic [63:0] ve, vm;
        int          errs_before;
        last_data = 64'h0;
        errs_before = failures;
        for (int i = 0; i < 400; i++) begin
            idle = (q.size() == 0);
            cur = idle ? '{en: 1'b0, a: 4'hF, d: 64'h0, r: 1'b0} : q.pop_front();
            exp_rdy = idle || cur.r;
            e = cur.en ? ev(1'b1, cur.a, cur.d, cur.r, exp_rdy) : ev(1'b0, 4'hF, last_data, cur.r, exp_rdy);
            o = sample();
            checks++;
            if (o !== e) begin
                failures++;
                if (failures - errs_before <= 10)
                    $display("FAIL random_cycle_%0d: got %h want %h", i, o, e);
            end
            if (cur.en) last_data = cur.d;
            if (cur.r) exp_retired++;

            if (i < 390 && $urandom_range(3) != 0) begin
                de = ($urandom_range(3) == 0) ? 4'hF : 4'($urandom_range(14));
                case ($urandom_range(3))
                    0, 1: dm = 4'hF;
                    2:    dm = de;
                    default: dm = 4'($urandom_range(14));
                endcase
                ve = {$urandom, $urandom};
                vm = {$urandom, $urandom};
                drive(de, ve, dm, vm);
                if (exp_rdy) begin
                    if (de != 4'hF && de != dm)
                        q.push_back('{en: 1'b1, a: de, d: ve, r: (dm == 4'hF)});
                    if (dm != 4'hF)
                        q.push_back('{en: 1'b1, a: dm, d: vm, r: 1'b1});
                    if (de == 4'hF && dm == 4'hF)
                        q.push_back('{en: 1'b0, a: 4'hF, d: 64'h0, r: 1'b1});
                    if (de != 4'hF && dm != 4'hF && de != dm)
                        exp_dual++;
                end
            end else begin
                drive_idle();
            end
            @(negedge clk);
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL random_drain: got %0d pending writes want 0", q.size());
        end
        check_perf("random");
    endtask

    initial begin
        wb.in_valid = 1'b0;
        wb.in_dstE  = 4'hF;
        wb.in_valE  = 64'h0;
        wb.in_dstM  = 4'hF;
        wb.in_valM  = 64'h0;
        test_reset();
        test_opq_back_to_back();
        test_popq_rbx();
        test_popq_rsp();
        test_nop();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
